// File: rtl/bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter, its update rule,
// and the scheduler FSM state encoding.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_ST  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Taken saturates upward; not-taken drops strong to weak and weak straight to strong-not-taken.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr_t'(ctr + 2'd1);
    end else begin
      case (ctr)
        CTR_ST:  nxt = CTR_WT;
        default: nxt = CTR_SNT;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_scheduler_if.sv
// Lookup/update handshake bundle between the front/back end and the BHT scheduler.
interface bht_scheduler_if #(
  parameter int unsigned IDX_W = 4
);
  logic             pred_req;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_ready;
  logic             pred_valid;
  logic             pred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_ready;
  logic             init_busy;

  modport slave (
    input  pred_req, pred_idx, upd_valid, upd_idx, upd_taken,
    output pred_ready, pred_valid, pred_taken, upd_ready, init_busy
  );

  modport master (
    output pred_req, pred_idx, upd_valid, upd_idx, upd_taken,
    input  pred_ready, pred_valid, pred_taken, upd_ready, init_busy
  );
endinterface

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO holding pending resolve updates; registered full/empty flags.
module bp_upd_fifo #(
  parameter int unsigned W     = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] rd_data_c,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == (AW+1)'(DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  assign rd_data_c = mem_q[rd_q];
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/bht_scheduler.sv
// Branch history table with a single access port shared between lookups and
// buffered resolve updates; sweeps the table to INIT_CTR after every reset.
module bht_scheduler
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned UQ_DEPTH = 4,
  parameter ctr_t        INIT_CTR = 2'b11
) (
  input  logic          clk,
  input  logic          rst_n,
  bht_scheduler_if.slave bus
);

  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned UQ_W    = IDX_W + 1;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  ctr_t             table_q [ENTRIES];

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic [UQ_W-1:0]  fifo_head;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;

  logic             sweep_c;
  logic             lookup_c;
  logic             drain_c;
  logic             pred_ready_c;
  logic             upd_ready_c;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic             init_busy_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Port arbitration: full FIFO drains first, then lookups, then idle drains.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sweep_c      = 1'b0;
    lookup_c     = 1'b0;
    drain_c      = 1'b0;
    pred_ready_c = 1'b0;
    upd_ready_c  = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_INIT: begin
          sweep_c = 1'b1;
          ptr_d   = ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = ST_RUN;
        end
        ST_RUN: begin
          pred_ready_c = !fifo_full;
          upd_ready_c  = !fifo_full;
          if (fifo_full)         drain_c  = 1'b1;
          else if (bus.pred_req) lookup_c = 1'b1;
          else if (!fifo_empty)  drain_c  = 1'b1;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign fifo_push = bus.upd_valid && upd_ready_c;

  bp_upd_fifo #(
    .W     (UQ_W),
    .DEPTH (UQ_DEPTH)
  ) u_upd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .din       ({bus.upd_idx, bus.upd_taken}),
    .pop       (drain_c),
    .rd_data_c (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_idx, head_taken} = fifo_head;

  // Single write port: sweep or read-modify-write of the FIFO head.
  always_ff @(posedge clk) begin
    if (sweep_c)      table_q[ptr_q]    <= INIT_CTR;
    else if (drain_c) table_q[head_idx] <= ctr_next(table_q[head_idx], head_taken);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      init_busy_q  <= 1'b1;
    end else begin
      pred_valid_q <= lookup_c;
      init_busy_q  <= (state_d == ST_INIT);
      if (lookup_c) pred_taken_q <= table_q[bus.pred_idx][1];
    end
  end

  assign bus.pred_ready = pred_ready_c;
  assign bus.upd_ready  = upd_ready_c;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_taken = pred_taken_q;
  assign bus.init_busy  = init_busy_q;

endmodule

// File: tb/tb_bht_scheduler.sv
// Scoreboard bench for bht_scheduler: a behavioural table/queue model predicts
// handshakes and lookup results; a separate monitor compares pred_valid/pred_taken.
module tb_bht_scheduler;
  import bp_pkg::*;

  localparam int unsigned IDX_W    = 4;
  localparam int unsigned UQ_DEPTH = 4;
  localparam int          N        = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bht_scheduler_if #(.IDX_W(IDX_W)) bus ();

  bht_scheduler #(
    .IDX_W    (IDX_W),
    .UQ_DEPTH (UQ_DEPTH),
    .INIT_CTR (2'b11)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct { int cyc; int taken; } exp_t;
  typedef struct { int idx; int taken; } upd_t;

  exp_t pend[$];
  upd_t mq[$];
  int   mtab [N];
  int   init_left = N;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Saturating 2-bit counter as described: taken climbs to 3; not-taken 3->2, else ->0.
  function automatic int sat(input int c, input int t);
    if (t != 0) return (c < 3) ? c + 1 : 3;
    return (c == 3) ? 2 : 0;
  endfunction

  function automatic void model_drain();
    upd_t u;
    u = mq.pop_front();
    mtab[u.idx] = sat(mtab[u.idx], u.taken);
  endfunction

  // Reference model: compares handshakes, then advances one clock edge.
  always @(negedge clk) begin
    bit run;
    bit full;
    if (cyc >= 1) begin
      run  = (init_left == 0);
      full = (mq.size() == UQ_DEPTH);
      check("init_busy", int'(bus.init_busy), int'(init_left > 0));
      check("pred_ready", int'(bus.pred_ready), int'(rst_n && run && !full));
      check("upd_ready", int'(bus.upd_ready), int'(rst_n && run && !full));
      if (!rst_n) begin
        init_left = N;
        mq.delete();
        while (pend.size() > 0 && pend[$].cyc > cyc) void'(pend.pop_back());
      end else if (!run) begin
        mtab[N - init_left] = 3;
        init_left--;
      end else begin
        if (full) model_drain();
        else if (bus.pred_req) pend.push_back('{cyc + 1, int'(mtab[bus.pred_idx] >= 2)});
        else if (mq.size() > 0) model_drain();
        if (!full && bus.upd_valid) mq.push_back('{int'(bus.upd_idx), int'(bus.upd_taken)});
      end
    end
  end

  // Monitor: every pred_valid must match the oldest due expectation, and vice versa.
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 1) begin
      if (bus.pred_valid === 1'b1) begin
        if (pend.size() > 0 && pend[0].cyc == cyc) begin
          e = pend.pop_front();
          check("pred_taken", int'(bus.pred_taken), e.taken);
        end else begin
          check("pred_valid_unexpected", int'(bus.pred_valid), 0);
        end
      end else if (pend.size() > 0 && pend[0].cyc <= cyc) begin
        void'(pend.pop_front());
        check("pred_valid_missing", int'(bus.pred_valid), 1);
      end
    end
  end

  task automatic drive(input bit req, input int pidx, input bit uv, input int uidx, input bit ut);
    bus.pred_req  = req;
    bus.pred_idx  = IDX_W'(pidx);
    bus.upd_valid = uv;
    bus.upd_idx   = IDX_W'(uidx);
    bus.upd_taken = ut;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic lookup(input int idx);
    drive(1'b1, idx, 1'b0, 0, 1'b0);
  endtask

  task automatic update(input int idx, input bit t);
    drive(1'b0, 0, 1'b1, idx, t);
  endtask

  initial begin
    bus.pred_req  = 1'b0;
    bus.pred_idx  = '0;
    bus.upd_valid = 1'b0;
    bus.upd_idx   = '0;
    bus.upd_taken = 1'b0;
    rst_n = 1'b0;

    // Reset and init sweep with pred_req held high, then lookup idx 9.
    repeat (3) lookup(9);
    rst_n = 1'b1;
    repeat (16) lookup(9);
    lookup(9);
    idle(2);

    // Two not-taken updates to idx 5, then lookups of 5 and 6.
    update(5, 1'b0);
    update(5, 1'b0);
    idle(3);
    lookup(5);
    lookup(6);
    idle(2);

    // Walk idx 3 up from 00 to saturation.
    update(3, 1'b0);
    update(3, 1'b0);
    idle(2);
    update(3, 1'b1);
    idle(1);
    lookup(3);
    update(3, 1'b1);
    idle(1);
    lookup(3);
    repeat (3) update(3, 1'b1);
    idle(3);
    lookup(3);
    idle(2);

    // Fill the FIFO behind continuous lookups, then keep looking up.
    for (int i = 0; i < 4; i++) drive(1'b1, i, 1'b1, 10 + i, 1'b0);
    repeat (8) lookup($urandom_range(N - 1));
    idle(6);

    // Three updates queued behind lookups, then a one-cycle reset mid-operation.
    for (int i = 0; i < 3; i++) drive(1'b1, i, 1'b1, 12, 1'b0);
    rst_n = 1'b0;
    lookup(0);
    rst_n = 1'b1;
    repeat (16) lookup(7);
    for (int i = 0; i < N; i++) lookup(i);
    idle(2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
      drive(($urandom_range(9) < 6), $urandom_range(N - 1),
            ($urandom_range(1) == 1), $urandom_range(N - 1), ($urandom_range(1) == 1));
    end
    rst_n = 1'b1;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bht_scheduler.md
# bht_scheduler

Owns a table of 2^IDX_W two-bit branch counters and schedules its single access port between front-end prediction lookups and back-end resolve updates. Resolve updates are buffered in a small FIFO and drained in idle cycles. A full FIFO forces a drain ahead of lookups. After reset the block sweeps the table to the initial counter value before serving any lookup.

## Interface
- IDX_W, 4: table index width; the table holds 2^IDX_W entries.
- UQ_DEPTH, 4: update FIFO depth, power of two, minimum 2.
- INIT_CTR, 2'b11: counter value written to every entry during the init sweep.

- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  synchronous, active-low reset.
- pred_req  in  1  lookup request; sampled only when pred_ready=1.
- pred_idx  in  IDX_W  lookup index.
- pred_ready  out  1  lookup accepted this cycle (combinational from state and FIFO full).
- pred_valid  out  1  registered; pred_taken is valid this cycle.
- pred_taken  out  1  registered; MSB of the looked-up counter.
- upd_valid  in  1  resolve update offered.
- upd_idx  in  IDX_W  index to update.
- upd_taken  in  1  actual branch outcome.
- upd_ready  out  1  update accepted when upd_valid && upd_ready.
- init_busy  out  1  high while the init sweep runs.

## Operation
- FSM has two states, INIT and RUN. Reset forces INIT with the sweep pointer at 0, and clears the FIFO.
- INIT: one entry per cycle, table[ptr] <= INIT_CTR. After index 2^IDX_W-1 is written the FSM moves to RUN. In INIT, pred_ready=0 and upd_ready=0.
- RUN arbitration applies once per cycle, in priority order:
  - FIFO full: drain the head; pred_ready=0.
  - Else pred_req: perform the lookup; no drain this cycle.
  - Else FIFO not empty: drain the head.
- upd_ready = RUN && !full. When the FIFO is full in a cycle, no enqueue happens that cycle, even if the head drains.
- Drain is a read-modify-write of table[head.idx] with ctr_next.
  - Taken: 00→01, 01→10, 10→11, 11→11.
  - Not taken: 11→10, 10→00, 01→00, 00→00.
- A lookup returns the table contents as of the lookup cycle. Updates still in the FIFO are not forwarded.
- Counter arithmetic is exactly 2 bits and saturates. The sweep pointer is IDX_W+1 bits, or the terminal-count compare uses IDX_W bits; neither may wrap into a second sweep.
- Reset mid-operation: every queued update is dropped, any in-flight pred_valid is cancelled, and the full sweep reruns.

## Timing
- Reset values: pred_valid=0, pred_taken=0, init_busy=1, pred_ready=0, upd_ready=0, FIFO empty.
- Init takes 2^IDX_W cycles after the first cycle with rst_n=1. init_busy falls, and pred_ready/upd_ready may rise, on the cycle after the last sweep write.
- Lookup latency is 1. A request accepted at edge t produces pred_valid=1 with pred_taken after edge t, for one cycle only.
- Back-to-back lookups are supported at one per cycle while the FIFO is not full.
- An update enqueued at edge t can reach the table at edge t+1 at the earliest, if the cycle after t has no accepted lookup. A lookup of the same index at the same edge reads the old value.
- A full FIFO costs exactly one lookup-blocked cycle per drain.

## Structure
- Shared package bp_pkg holds:
  - typedef ctr_t (2 bits)
  - constants CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11
  - function ctr_next(ctr_t, taken)
  - the FSM state enum
- The existing predictor and future predictor blocks reuse ctr_next.
- One sub-module, bp_upd_fifo: a synchronous FIFO of {idx, taken} with full/empty flags, reset by the same rst_n.
- The table is a register array local to bht_scheduler.

## Test plan
All scenarios use IDX_W=4 and UQ_DEPTH=4.

- Reset release, pred_req held high: init_busy=1 for 16 cycles, pred_ready=0 throughout. Then a lookup of idx 9 returns pred_valid=1, pred_taken=1 one cycle later.
- Two not-taken updates to idx 5 with pred_req low: lookup idx 5 gives 0 (11→10→00); lookup idx 6 gives 1.
- From 00 at idx 3: one taken update, lookup gives 0 (01). A second taken update, lookup gives 1 (10). Three more taken updates, lookup gives 1 (saturated at 11).
- pred_req held high continuously while 4 updates are pushed: FIFO fills and upd_ready=0. Next cycle pred_ready=0 and one entry drains. pred_ready then returns to 1 and lookups resume at 1 per cycle.
- Three updates queued behind continuous lookups, then rst_n=0 for one cycle: the FIFO empties, the 16-cycle sweep reruns, and every index afterwards predicts 1.
- pred_req asserted during INIT: no pred_valid pulse is ever produced for it.
